// File: rtl/wb_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : wb_gpio_irq
// Brief    : Wishbone classic GPIO controller with edge-triggered level IRQ.
//            Define GPIO_DEBOUNCE_EN to add a per-bit input debounce filter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_gpio_irq #(
    parameter int          GPIO_WIDTH      = 8,
    parameter logic [31:0] OUT_RESET       = 32'h0000_0000,
    parameter int          DEBOUNCE_CYCLES = 240000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [2:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_dir_o,
    output logic                  irq_o
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_ACK  = 1'b1;

    localparam logic [2:0] c_ADR_DATA_IN    = 3'd0;
    localparam logic [2:0] c_ADR_DATA_OUT   = 3'd1;
    localparam logic [2:0] c_ADR_DIR        = 3'd2;
    localparam logic [2:0] c_ADR_IRQ_MASK   = 3'd3;
    localparam logic [2:0] c_ADR_IRQ_RISE   = 3'd4;
    localparam logic [2:0] c_ADR_IRQ_FALL   = 3'd5;
    localparam logic [2:0] c_ADR_IRQ_STATUS = 3'd6;

    logic [0:0]            r_state;
    logic [GPIO_WIDTH-1:0] r_s1;
    logic [GPIO_WIDTH-1:0] r_s2;
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [GPIO_WIDTH-1:0] r_data_out;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_mask;
    logic [GPIO_WIDTH-1:0] r_rise_en;
    logic [GPIO_WIDTH-1:0] r_fall_en;
    logic [GPIO_WIDTH-1:0] r_status;

    logic [GPIO_WIDTH-1:0] w_din;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_fall;
    logic [GPIO_WIDTH-1:0] w_set;
    logic [GPIO_WIDTH-1:0] w_clr;
    logic [GPIO_WIDTH-1:0] w_wdat;
    logic [GPIO_WIDTH-1:0] w_wmask;
    logic [31:0]           w_be;
    logic [31:0]           w_rdata;
    logic                  w_access;
    logic                  w_wr;
    logic                  w_unused;

    // An access is taken only from IDLE, so a held strobe is acked every other cycle.
    assign w_access = wb_cyc_i & wb_stb_i & ~wb_ack_o & (r_state == c_IDLE);
    assign w_wr     = w_access & wb_we_i;

    assign w_be    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_wmask = w_be[GPIO_WIDTH-1:0];
    assign w_wdat  = wb_dat_i[GPIO_WIDTH-1:0];

    function automatic logic [GPIO_WIDTH-1:0] f_merge(input logic [GPIO_WIDTH-1:0] old_val);
        f_merge = (old_val & ~w_wmask) | (w_wdat & w_wmask);
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            r_state  <= w_access ? c_ACK : c_IDLE;
            wb_ack_o <= w_access;
            wb_dat_o <= w_access ? w_rdata : 32'h0;
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        case (wb_adr_i)
            c_ADR_DATA_IN:    w_rdata = 32'(w_din);
            c_ADR_DATA_OUT:   w_rdata = 32'(r_data_out);
            c_ADR_DIR:        w_rdata = 32'(r_dir);
            c_ADR_IRQ_MASK:   w_rdata = 32'(r_mask);
            c_ADR_IRQ_RISE:   w_rdata = 32'(r_rise_en);
            c_ADR_IRQ_FALL:   w_rdata = 32'(r_fall_en);
            c_ADR_IRQ_STATUS: w_rdata = 32'(r_status);
            default:          w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_data_out <= OUT_RESET[GPIO_WIDTH-1:0];
            r_dir      <= '0;
            r_mask     <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
        end else if (w_wr) begin
            case (wb_adr_i)
                c_ADR_DATA_OUT: r_data_out <= f_merge(r_data_out);
                c_ADR_DIR:      r_dir      <= f_merge(r_dir);
                c_ADR_IRQ_MASK: r_mask     <= f_merge(r_mask);
                c_ADR_IRQ_RISE: r_rise_en  <= f_merge(r_rise_en);
                c_ADR_IRQ_FALL: r_fall_en  <= f_merge(r_fall_en);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= gpio_i;
            r_s2   <= r_s1;
            r_prev <= w_din;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [GPIO_WIDTH-1:0] w_filt;

    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_debounce
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_filt;

        // The count restarts whenever the synchronized input agrees with the filtered value.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_cnt  <= '0;
                r_filt <= 1'b0;
            end else if (r_s2[gi] == r_filt) begin
                r_cnt  <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_cnt  <= '0;
                r_filt <= r_s2[gi];
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end

        assign w_filt[gi] = r_filt;
    end

    assign w_din    = w_filt;
    assign w_unused = ^{wb_dat_i, w_be};
`else
    assign w_din    = r_s2;
    assign w_unused = ^{wb_dat_i, w_be, 32'(DEBOUNCE_CYCLES)};
`endif

    assign w_rise = w_din & ~r_prev;
    assign w_fall = ~w_din & r_prev;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = (w_wr && (wb_adr_i == c_ADR_IRQ_STATUS)) ? (w_wdat & w_wmask) : '0;

    // A new edge event wins over a W1C landing on the same bit in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_status <= '0;
            irq_o    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_set;
            irq_o    <= |(r_status & r_mask);
        end
    end

    assign gpio_o     = r_data_out;
    assign gpio_dir_o = r_dir;

endmodule
`default_nettype wire

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
- Wishbone classic slave GPIO controller inside picorv32_wb_soc.
- Produces gpio0_o and gpio0_dir_o, which drive the board LEDs and IO pads at top level.
- Samples gpio0_i through a 2-flop synchronizer.
- Raises a level interrupt on selectable input edges.
- Single clock domain (wb_clk).

Parameters:
- GPIO_WIDTH, 8, number of GPIO lines (1..32).
- OUT_RESET, 0, reset value of the DATA_OUT register.
- DEBOUNCE_CYCLES, 240000, stable-sample count for the debounce filter (10 ms at 24 MHz); used only with the optional feature.

Ports:
- clock  in  1  Wishbone clock.
- reset_n  in  1  synchronous active-low reset.
- wb_adr_i  in  3  word address, byte address bits [4:2].
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- gpio_i  in  GPIO_WIDTH  pad inputs (asynchronous).
- gpio_o  out  GPIO_WIDTH  output values.
- gpio_dir_o  out  GPIO_WIDTH  1 = output enable per bit.
- irq_o  out  1  interrupt request.

Behaviour:
- Reset is synchronous: all state updates on the clock edge where reset_n=0. Reset values:
  - gpio_o=OUT_RESET, gpio_dir_o=0, irq_o=0, wb_ack_o=0, wb_dat_o=0.
  - Synchronizer flops, edge registers, IRQ_MASK and IRQ_STATUS all cleared.
- Register map (word offsets); bits above GPIO_WIDTH read 0 and ignore writes:
  - 0 DATA_IN (RO): synchronized input.
  - 1 DATA_OUT (RW).
  - 2 DIR (RW).
  - 3 IRQ_MASK (RW).
  - 4 IRQ_RISE (RW): enable rising-edge detect per bit.
  - 5 IRQ_FALL (RW): enable falling-edge detect per bit.
  - 6 IRQ_STATUS (R/W1C).
  - 7 reserved: reads 0, writes ignored, still acked.
- Handshake FSM, states IDLE and ACK:
  - IDLE -> ACK when cyc&stb&!ack; wb_ack_o=1 for exactly one cycle.
  - ACK -> IDLE unconditionally.
  - Back-to-back transfers therefore ack every second cycle.
  - Register write commits on the same edge that raises ack.
  - wb_dat_o is valid while ack=1 and is 0 otherwise.
  - If cyc drops during IDLE, no access happens.
- Byte lanes: write updates only bytes whose wb_sel_i bit is set. sel=0 write is acked with no effect.
- Input path:
  - s1<=gpio_i, s2<=s1; DATA_IN=s2; prev<=s2.
  - rise=s2&~prev; fall=~s2&prev.
  - Input-to-DATA_IN latency: 2 clocks.
  - Edge detect applies to all bits regardless of DIR.
- IRQ_STATUS:
  - bit set when (rise&IRQ_RISE)|(fall&IRQ_FALL).
  - Set wins over a simultaneous W1C on the same bit; clearing other bits in that cycle proceeds.
  - Status records even when the mask bit is 0.
- irq_o is registered: irq_o <= |(IRQ_STATUS & IRQ_MASK), i.e. 1 clock after status/mask change.
- After reset, prev is 0: an input held high through reset yields one rising edge 3 clocks after reset release, if IRQ_RISE is set by then. Otherwise it is not recorded.
- Reset asserted mid-transfer: ack forced 0, FSM to IDLE, pending write discarded.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined:
  - Per-bit counter after the synchronizer. The filtered bit changes only after s2 differs from the filtered value for DEBOUNCE_CYCLES consecutive clocks; the counter resets whenever s2 equals the filtered value.
  - DATA_IN and edge detection use the filtered value.
  - Filtered value resets to 0.
- Not defined: no counters; behaviour exactly as above.

Test Plan:
- Reset then read all 8 offsets -> DATA_OUT=OUT_RESET, all others 0, each read acked exactly 1 cycle after stb.
- Write DATA_OUT=0x000000A5 sel=4'b0001, then 0xFFFFFF3C sel=4'b0000 -> gpio_o=0xA5. Write DIR=0xFF -> gpio_dir_o=0xFF.
- gpio_i 0x00->0x10 with IRQ_RISE=0x10, IRQ_MASK=0x10:
  - DATA_IN=0x10 after 2 clocks.
  - IRQ_STATUS bit4 set after 3 clocks; irq_o=1 one clock later.
  - W1C 0x10 -> irq_o=0 one clock after the ack edge.
- Falling edge on bit 2 coinciding with a W1C of 0x04, IRQ_FALL=0x04 -> bit 2 remains set.
- Hold stb&cyc for 6 cycles -> exactly 3 ack pulses, alternating cycles. Assert reset_n=0 during a write's ack cycle -> register unchanged, ack=0 next cycle.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
  - 3-clock glitch on bit 0 -> DATA_IN unchanged.
  - 6-clock pulse -> DATA_IN bit0=1 after 2+4 clocks.
